countdown_timer_ms: RTL

- Down-counting companion to the team's up-counting stopwatch: loads an hh:mm:ss.ms preset, decrements once per millisecond tick and flags expiry at 00:00:00.000.
- Sits beside the stopwatch in the timekeeping cluster and shares its field widths and output format.
- Its outputs drive the same display path.
- Expiry is signalled through a level flag that the consumer must acknowledge.

---
 rtl/countdown_pkg.sv | 38 +++
 rtl/countdown_timer_ms_mod_down_counter.sv | 29 ++
 rtl/countdown_timer_ms.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/countdown_pkg.sv
// Shared widths, limits, state encoding and helpers for the countdown timer.
package countdown_pkg;

   localparam int HOUR_W  = 5;
   localparam int MIN_W   = 6;
   localparam int SEC_W   = 6;
   localparam int MS_W    = 10;

   localparam int MS_MAX  = 999;
   localparam int SEC_MAX = 59;
   localparam int MIN_MAX = 59;

   typedef enum logic [1:0] {
      IDLE,
      PAUSED,
      RUN,
      EXPIRED
   } state_t;

   typedef struct packed {
      logic [HOUR_W-1:0] hour;
      logic [MIN_W-1:0]  min;
      logic [SEC_W-1:0]  sec;
      logic [MS_W-1:0]   ms;
   } time_t;

   // Saturate each field independently so a bad preset never escapes the legal range.
   function automatic time_t clamp_time(input time_t t, input logic [HOUR_W-1:0] hour_max);
      time_t c;
      c = t;
      if (t.ms > MS_W'(MS_MAX)) c.ms = MS_W'(MS_MAX);
      if (t.sec > SEC_W'(SEC_MAX)) c.sec = SEC_W'(SEC_MAX);
      if (t.min > MIN_W'(MIN_MAX)) c.min = MIN_W'(MIN_MAX);
      if (t.hour > hour_max) c.hour = hour_max;
      return c;
   endfunction

endpackage

// File: rtl/countdown_timer_ms_mod_down_counter.sv
// Loadable modulo down-counter: wraps from 0 to MAX and flags the borrow.
module mod_down_counter
   import countdown_pkg::*;
#(
   parameter int WIDTH = 6,
   parameter int MAX   = 59
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_value_i,
   input  logic             dec_i,
   output logic [WIDTH-1:0] value_o,
   output logic             borrow_o
);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         value_o <= '0;
      end else if (load_i) begin
         value_o <= load_value_i;
      end else if (dec_i) begin
         value_o <= (value_o == '0) ? WIDTH'(MAX) : value_o - 1'b1;
      end
   end

   assign borrow_o = dec_i && (value_o == '0);

endmodule

// File: rtl/countdown_timer_ms.sv
// hh:mm:ss.ms countdown timer with latched expiry flag.
// Define COUNTDOWN_AUTO_RELOAD_EN for periodic reload from the last preset with a one-cycle expiry pulse.
module countdown_timer_ms
   import countdown_pkg::*;
#(
   parameter int TICKS_PER_MS = 1,
   parameter int HOUR_MAX     = 23
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              load_i,
   input  logic [HOUR_W-1:0] hour_set_i,
   input  logic [MIN_W-1:0]  min_set_i,
   input  logic [SEC_W-1:0]  sec_set_i,
   input  logic [MS_W-1:0]   ms_set_i,
   input  logic              start_stop_i,
   input  logic              ack_i,
   output logic [HOUR_W-1:0] hour_o,
   output logic [MIN_W-1:0]  min_o,
   output logic [SEC_W-1:0]  sec_o,
   output logic [MS_W-1:0]   ms_o,
   output logic              running_o,
   output logic              expired_o
);

   localparam int PRESC_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_MS - 1);
   localparam logic [HOUR_W-1:0]  HOUR_LIMIT = HOUR_W'(HOUR_MAX);

   state_t state_q, state_d;
   logic expired_q, expired_d;
   logic [PRESC_W-1:0] presc_q;
   logic presc_clr;
   logic tick;
   logic cnt_load;
   logic cnt_dec;
   logic at_one;
   time_t raw_preset;
   time_t preset;
   time_t load_val;
   time_t cur;
   logic [HOUR_W-1:0] hour_q;
   logic ms_borrow, sec_borrow, min_borrow;

   assign raw_preset = {hour_set_i, min_set_i, sec_set_i, ms_set_i};
   assign preset     = clamp_time(raw_preset, HOUR_LIMIT);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
   time_t shadow_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         shadow_q <= '0;
      end else if (load_i) begin
         shadow_q <= preset;
      end
   end

   assign load_val = load_i ? preset : shadow_q;
`else
   assign load_val = preset;
`endif

   assign cur    = {hour_q, min_o, sec_o, ms_o};
   assign at_one = (hour_q == '0) && (min_o == '0) && (sec_o == '0) && (ms_o == MS_W'(1));
   assign tick   = (state_q == RUN) && (presc_q == PRESC_LAST);

   always_ff @(posedge clk_i) begin
      if (reset_i || presc_clr) begin
         presc_q <= '0;
      end else if (state_q == RUN) begin
         presc_q <= tick ? '0 : presc_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         expired_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         expired_q <= expired_d;
      end
   end

   // EXPIRED is unreachable in auto-reload builds, so ack_i then has no effect.
   always_comb begin
      state_d   = state_q;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      expired_d = 1'b0;
`else
      expired_d = expired_q;
`endif
      presc_clr = 1'b0;
      cnt_load  = 1'b0;
      cnt_dec   = 1'b0;
      if (load_i) begin
         cnt_load  = 1'b1;
         presc_clr = 1'b1;
         expired_d = 1'b0;
         state_d   = (preset == '0) ? IDLE : PAUSED;
      end else if (ack_i && (state_q == EXPIRED)) begin
         state_d   = IDLE;
         expired_d = 1'b0;
      end else if (start_stop_i && (state_q == PAUSED)) begin
         state_d   = RUN;
         presc_clr = 1'b1;
      end else if (start_stop_i && (state_q == RUN)) begin
         state_d   = PAUSED;
      end else if (tick && (cur != '0)) begin
         if (at_one) begin
            expired_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            cnt_load  = 1'b1;
`else
            cnt_dec   = 1'b1;
            state_d   = EXPIRED;
`endif
         end else begin
            cnt_dec = 1'b1;
         end
      end
   end

   mod_down_counter #(.WIDTH(MS_W), .MAX(MS_MAX)) u_ms (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .load_i       (cnt_load),
      .load_value_i (load_val.ms),
      .dec_i        (cnt_dec),
      .value_o      (ms_o),
      .borrow_o     (ms_borrow)
   );

   mod_down_counter #(.WIDTH(SEC_W), .MAX(SEC_MAX)) u_sec (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .load_i       (cnt_load),
      .load_value_i (load_val.sec),
      .dec_i        (ms_borrow),
      .value_o      (sec_o),
      .borrow_o     (sec_borrow)
   );

   mod_down_counter #(.WIDTH(MIN_W), .MAX(MIN_MAX)) u_min (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .load_i       (cnt_load),
      .load_value_i (load_val.min),
      .dec_i        (sec_borrow),
      .value_o      (min_o),
      .borrow_o     (min_borrow)
   );

   // A minute borrow implies a nonzero hour, since the counter never decrements from zero.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         hour_q <= '0;
      end else if (cnt_load) begin
         hour_q <= load_val.hour;
      end else if (min_borrow) begin
         hour_q <= hour_q - 1'b1;
      end
   end

   assign hour_o    = hour_q;
   assign running_o = (state_q == RUN);
   assign expired_o = expired_q;

endmodule
